// File: rtl/score_pkg.sv
// score_pkg: shared types, segment codes and helpers
// for the score_display block.
package score_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        LOAD    = 2'd2
    } state_t;

    // Active-low gfedcba codes; a 0 lights a segment.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Largest displayable value, 10^digits - 1.
    function automatic logic [63:0] max_val(input int digits);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < digits; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

    // One digit code; out-of-range BCD shows blank.
    function automatic logic [6:0] seg_code(
        input logic [3:0] d,
        input logic       blank,
        input logic       active_low
    );
        logic [6:0] c;
        case (d)
            4'd0:    c = SEG_0;
            4'd1:    c = SEG_1;
            4'd2:    c = SEG_2;
            4'd3:    c = SEG_3;
            4'd4:    c = SEG_4;
            4'd5:    c = SEG_5;
            4'd6:    c = SEG_6;
            4'd7:    c = SEG_7;
            4'd8:    c = SEG_8;
            4'd9:    c = SEG_9;
            default: c = SEG_BLANK;
        endcase
        if (blank) begin
            c = SEG_BLANK;
        end
        return active_low ? c : ~c;
    endfunction

endpackage

// File: rtl/seg7_encode.sv
// seg7_encode: combinational BCD digit to
// seven-segment code with blanking and polarity.
module seg7_encode
    import score_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    input  logic       active_low,
    output logic [6:0] seg
);

    // Pure lookup, shared with the reset encoding.
    always_comb begin
        seg = seg_code(bcd, blank, active_low);
    end

endmodule

// File: rtl/score_display.sv
// score_display: binary score to registered
// seven-segment digits via serial double-dabble.
module score_display
    import score_pkg::*;
#(
    parameter int DIGITS         = 2,
    parameter int WIDTH          = 32,
    parameter int ACTIVE_LOW_SEG = 1,
    parameter int BLANK_LZ       = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      score,
    input  logic                  score_valid,
    output logic                  busy,
    output logic [7*DIGITS-1:0]   seg_out,
    output logic                  overflow
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;
    localparam logic [63:0] MAX64 = max_val(DIGITS);
    localparam bit SAT_EN = (MAX64 < (64'd1 << WIDTH));
    localparam logic [WIDTH-1:0] MAX_W = MAX64[WIDTH-1:0];
    localparam logic POL = (ACTIVE_LOW_SEG != 0);
    localparam logic BLZ = (BLANK_LZ != 0);

    // Display value of 0: digit 0 shown, rest per blanking.
    function automatic logic [7*DIGITS-1:0] rst_code();
        logic [7*DIGITS-1:0] r;
        for (int k = 0; k < DIGITS; k++) begin
            r[7*k +: 7] = seg_code(4'd0, (k != 0) && BLZ, POL);
        end
        return r;
    endfunction

    localparam logic [7*DIGITS-1:0] SEG_RST = rst_code();

    state_t              state_q, state_d;
    logic                pend_q, pend_d;
    logic [WIDTH-1:0]    pend_val_q, pend_val_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]    shift_q, shift_d;
    logic [BW-1:0]       bcd_q, bcd_d;
    logic                sat_q, sat_d;
    logic                ovf_q, ovf_d;
    logic [7*DIGITS-1:0] seg_q, seg_d;

    logic [BW-1:0]       bcd_adj;
    logic [DIGITS-1:0]   blank;
    logic                lz;
    logic [7*DIGITS-1:0] enc;
    logic [WIDTH-1:0]    cap_src;
    logic                do_cap;
    logic                cap_sat;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (score_valid) state_d = CONVERT;
            end
            CONVERT: begin
                if (cnt_q == CW'(WIDTH - 1)) state_d = LOAD;
            end
            LOAD: begin
                if (score_valid || pend_q) begin
                    state_d = CONVERT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state and output registers.
    always_comb begin
        busy     = (state_q != IDLE);
        seg_out  = seg_q;
        overflow = ovf_q;
    end

    // Add-3 correction of every BCD digit before the shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
            end
        end
    end

    // Leading-zero blanking, scanning down from the top digit.
    always_comb begin
        blank = '0;
        lz    = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            lz       = lz & (bcd_q[4*k +: 4] == 4'd0);
            blank[k] = lz & BLZ;
        end
    end

    for (genvar k = 0; k < DIGITS; k++) begin : g_enc
        seg7_encode u_enc (
            .bcd        (bcd_q[4*k +: 4]),
            .blank      (blank[k]),
            .active_low (POL),
            .seg        (enc[7*k +: 7])
        );
    end

    // Datapath: capture, pending slot, conversion step, load.
    always_comb begin
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        bcd_d      = bcd_q;
        sat_d      = sat_q;
        ovf_d      = ovf_q;
        seg_d      = seg_q;
        cap_src    = score;
        do_cap     = 1'b0;
        cap_sat    = 1'b0;
        case (state_q)
            IDLE: begin
                do_cap = score_valid;
            end
            CONVERT: begin
                if (score_valid) begin
                    pend_d     = 1'b1;
                    pend_val_d = score;
                end
                cnt_d   = cnt_q + CW'(1);
                shift_d = shift_q << 1;
                bcd_d   = {bcd_adj[BW-2:0], shift_q[WIDTH-1]};
            end
            LOAD: begin
                seg_d = enc;
                ovf_d = sat_q;
                if (score_valid) begin
                    do_cap = 1'b1;
                end else if (pend_q) begin
                    do_cap  = 1'b1;
                    cap_src = pend_val_q;
                    pend_d  = 1'b0;
                end
            end
            default: ;
        endcase
        if (do_cap) begin
            cap_sat = SAT_EN && (64'(cap_src) > MAX64);
            sat_d   = cap_sat;
            shift_d = cap_sat ? MAX_W : cap_src;
            bcd_d   = '0;
            cnt_d   = '0;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q     <= 1'b0;
            pend_val_q <= '0;
            cnt_q      <= '0;
            shift_q    <= '0;
            bcd_q      <= '0;
            sat_q      <= 1'b0;
            ovf_q      <= 1'b0;
            seg_q      <= SEG_RST;
        end else begin
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            bcd_q      <= bcd_d;
            sat_q      <= sat_d;
            ovf_q      <= ovf_d;
            seg_q      <= seg_d;
        end
    end

endmodule

// File: tb/tb_score_display.sv
// tb_score_display: scoreboard bench for two
// score_display configurations.
module tb_score_display;

    typedef struct {
        int          due;
        logic [27:0] seg;
        logic        ovf;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] score1, score2;
    logic        valid1, valid2;
    logic        busy1, busy2;
    logic [13:0] seg1;
    logic [27:0] seg2;
    logic        ovf1, ovf2;

    int   cyc;
    int   checks;
    int   failures;
    bit   seen34;
    exp_t q1[$];
    exp_t q2[$];

    score_display #(
        .DIGITS(2), .WIDTH(32)
    ) dut1 (
        .clk(clk), .rst_n(rst_n),
        .score(score1), .score_valid(valid1),
        .busy(busy1), .seg_out(seg1),
        .overflow(ovf1)
    );

    score_display #(
        .DIGITS(4), .WIDTH(32), .ACTIVE_LOW_SEG(0)
    ) dut2 (
        .clk(clk), .rst_n(rst_n),
        .score(score2), .score_valid(valid2),
        .busy(busy2), .seg_out(seg2),
        .overflow(ovf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string tag, longint got, longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] code(int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    function automatic exp_t model(int digits, bit al, longint v);
        exp_t       e;
        longint     mx;
        int         d[8];
        bit         lz;
        logic [6:0] c;
        mx = 1;
        for (int i = 0; i < digits; i++) mx = mx * 10;
        mx = mx - 1;
        e.ovf = (v > mx);
        if (v > mx) v = mx;
        for (int i = 0; i < digits; i++) begin
            d[i] = int'(v % 10);
            v = v / 10;
        end
        e.seg = '0;
        lz = 1'b1;
        for (int k = digits - 1; k >= 0; k--) begin
            lz = lz && (d[k] == 0) && (k != 0);
            c = lz ? 7'b1111111 : code(d[k]);
            if (!al) c = ~c;
            e.seg[7*k +: 7] = c;
        end
        e.due = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && seg1 == model(2, 1, 34).seg[13:0])
            seen34 = 1'b1;
        if (q1.size() > 0 && q1[0].due == cyc) begin
            exp_t e;
            e = q1.pop_front();
            check("seg1", seg1, e.seg[13:0]);
            check("ovf1", ovf1, e.ovf);
        end
        if (q2.size() > 0 && q2[0].due == cyc) begin
            exp_t e;
            e = q2.pop_front();
            check("seg2", seg2, e.seg);
            check("ovf2", ovf2, e.ovf);
        end
    end

    task automatic push1(int due, longint v);
        exp_t e;
        e = model(2, 1, v);
        e.due = due;
        q1.push_back(e);
    endtask

    task automatic pulse1(int v);
        score1 = 32'(v);
        valid1 = 1'b1;
        @(negedge clk);
        valid1 = 1'b0;
    endtask

    task automatic pulse2(int v);
        score2 = 32'(v);
        valid2 = 1'b1;
        @(negedge clk);
        valid2 = 1'b0;
    endtask

    task automatic wait_idle1(output int at);
        at = -1;
        for (int i = 0; i < 200; i++) begin
            if (!busy1) begin
                at = cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic run1(int v);
        int c, t;
        c = cyc;
        push1(c + 34, v);
        pulse1(v);
        wait_idle1(t);
        check("busy_len", t, c + 34);
        @(negedge clk);
    endtask

    task automatic run2(int v);
        exp_t e;
        e = model(4, 0, v);
        e.due = cyc + 34;
        q2.push_back(e);
        pulse2(v);
        repeat (40) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, t;
        checks   = 0;
        failures = 0;
        seen34   = 1'b0;
        rst_n    = 1'b0;
        valid1   = 1'b0;
        valid2   = 1'b0;
        score1   = '0;
        score2   = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_seg1", seg1, 14'b1111111_1000000);
        check("rst_ovf1", ovf1, 0);
        check("rst_busy1", busy1, 0);
        check("rst_seg2", seg2, model(4, 0, 0).seg);
        check("rst_busy2", busy2, 0);

        run1(7);
        check("seg7", seg1, 14'b1111111_1111000);
        run1(80);
        run1(89);
        run1(100);
        check("ovf100", ovf1, 1);
        run1(5);
        check("ovf5", ovf1, 0);

        c = cyc;
        seen34 = 1'b0;
        push1(c + 34, 12);
        push1(c + 67, 56);
        pulse1(12);
        repeat (5) @(negedge clk);
        pulse1(34);
        repeat (5) @(negedge clk);
        pulse1(56);
        wait_idle1(t);
        check("pend_busy_end", t, c + 67);
        check("no34", seen34, 0);
        @(negedge clk);

        run1(250);
        check("ovf250", ovf1, 1);
        pulse1(45);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_seg", seg1, 14'b1111111_1000000);
        check("mid_rst_ovf", ovf1, 0);
        check("mid_rst_busy", busy1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        check("post_rst_seg", seg1, 14'b1111111_1000000);
        check("post_rst_busy", busy1, 0);

        run2(1234);
        check("seg1234", seg2, 28'b0000110_1011011_1001111_1100110);
        run2(5);
        run2(10000);
        run2(0);

        check("q1_drain", q1.size(), 0);
        check("q2_drain", q2.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
